// File: rtl/ofdm_cp_remove_if.sv
// Sample stream bundle for ofdm_cp_remove: an unthrottled input side and a
// valid/ready output side. The master drives input samples and out_ready.
interface ofdm_cp_remove_if #(
    parameter int DWIDTH = 16
);
    logic [DWIDTH-1:0] in_re;
    logic [DWIDTH-1:0] in_im;
    logic              in_valid;
    logic              in_sof;
    logic              out_ready;
    logic [DWIDTH-1:0] out_re;
    logic [DWIDTH-1:0] out_im;
    logic              out_valid;
    logic              out_last;

    modport master (
        output in_re, in_im, in_valid, in_sof, out_ready,
        input  out_re, out_im, out_valid, out_last
    );

    modport slave (
        input  in_re, in_im, in_valid, in_sof, out_ready,
        output out_re, out_im, out_valid, out_last
    );
endinterface

// File: rtl/ofdm_cp_remove.sv
// Strips the cyclic prefix from each 64-point OFDM symbol and streams the body out of
// ping-pong banks. Define CPREM_OVF_STATUS_EN to expose the sticky overflow flag.
module ofdm_cp_remove #(
    parameter int DWIDTH = 16,
    parameter int CPLEN  = 16
) (
    input  logic            clk,
    input  logic            rst,
    ofdm_cp_remove_if.slave bus,
    output logic            overflow
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CP   = 2'd1,
        S_BODY = 2'd2
    } state_t;

    localparam logic [5:0] CP_LAST   = 6'(CPLEN - 1);
    localparam logic [5:0] ADDR_LAST = 6'd63;

    state_t              state_r, state_nxt_s;
    logic [5:0]          cp_cnt_r, cp_cnt_nxt_s;
    logic [5:0]          wr_addr_r, wr_addr_nxt_s;
    logic                wbank_r, wbank_nxt_s;
    logic                drop_r, drop_nxt_s;
    logic                enter_body_s, wr_en_s, wr_done_s;
    logic                wr_done_r, done_bank_r;
    logic [1:0]          full_r, full_nxt_s;
    logic                rbank_r, rd_issued_r;
    logic [5:0]          rd_addr_r;
    logic                q_vld_r, q_last_r;
    logic                adv_s, rd_en_s, last_xfer_s;
    logic [2*DWIDTH-1:0] mem_r [0:127];
    logic [2*DWIDTH-1:0] q_data_r;
    logic [DWIDTH-1:0]   out_re_r, out_im_r;
    logic                out_valid_r, out_last_r;

    // Input FSM: CP counting, body addressing and bank selection for each accepted sample
    always_comb begin
        state_nxt_s   = state_r;
        cp_cnt_nxt_s  = cp_cnt_r;
        wr_addr_nxt_s = wr_addr_r;
        wbank_nxt_s   = wbank_r;
        drop_nxt_s    = drop_r;
        enter_body_s  = 1'b0;
        wr_en_s       = 1'b0;
        wr_done_s     = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_sof) begin
                // the sof sample is CP sample 0; with a one-sample CP the body starts next
                if (CP_LAST == 6'd0) begin
                    enter_body_s = 1'b1;
                end else begin
                    state_nxt_s  = S_CP;
                    cp_cnt_nxt_s = 6'd1;
                end
            end else begin
                case (state_r)
                    S_IDLE: state_nxt_s = S_IDLE;
                    S_CP: begin
                        if (cp_cnt_r == CP_LAST) begin
                            enter_body_s = 1'b1;
                        end else begin
                            cp_cnt_nxt_s = cp_cnt_r + 6'd1;
                        end
                    end
                    S_BODY: begin
                        wr_en_s = ~drop_r;
                        if (wr_addr_r == ADDR_LAST) begin
                            state_nxt_s  = S_CP;
                            cp_cnt_nxt_s = 6'd0;
                            wr_done_s    = ~drop_r;
                            wbank_nxt_s  = wbank_r ^ ~drop_r;
                        end else begin
                            wr_addr_nxt_s = wr_addr_r + 6'd1;
                        end
                    end
                    default: state_nxt_s = S_IDLE;
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
        if (enter_body_s) begin
            state_nxt_s   = S_BODY;
            wr_addr_nxt_s = 6'd0;
            drop_nxt_s    = full_r[wbank_r];
        end else begin
            drop_nxt_s = drop_r;
        end
    end

    // Bank full flags: write completion and read completion always hit different banks
    always_comb begin
        full_nxt_s[0] = (full_r[0] | (wr_done_r & ~done_bank_r)) & ~(last_xfer_s & ~rbank_r);
        full_nxt_s[1] = (full_r[1] | (wr_done_r &  done_bank_r)) & ~(last_xfer_s &  rbank_r);
    end

    // Input-side state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            cp_cnt_r    <= 6'd0;
            wr_addr_r   <= 6'd0;
            wbank_r     <= 1'b0;
            drop_r      <= 1'b0;
            wr_done_r   <= 1'b0;
            done_bank_r <= 1'b0;
            full_r      <= 2'b00;
        end else begin
            state_r     <= state_nxt_s;
            cp_cnt_r    <= cp_cnt_nxt_s;
            wr_addr_r   <= wr_addr_nxt_s;
            wbank_r     <= wbank_nxt_s;
            drop_r      <= drop_nxt_s;
            wr_done_r   <= wr_done_s;
            done_bank_r <= wbank_r;
            full_r      <= full_nxt_s;
        end
    end

    assign adv_s       = ~out_valid_r | bus.out_ready;
    assign rd_en_s     = adv_s & full_r[rbank_r] & ~rd_issued_r;
    assign last_xfer_s = out_valid_r & bus.out_ready & out_last_r;

    // Ping-pong sample RAM, synchronous read
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[{wbank_r, wr_addr_r}] <= {bus.in_re, bus.in_im};
        end
        if (rd_en_s) begin
            q_data_r <= mem_r[{rbank_r, rd_addr_r}];
        end
    end

    // Read pipeline: RAM stage and output stage advance together, both hold on a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            rbank_r     <= 1'b0;
            rd_addr_r   <= 6'd0;
            rd_issued_r <= 1'b0;
            q_vld_r     <= 1'b0;
            q_last_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_re_r    <= '0;
            out_im_r    <= '0;
        end else begin
            if (rd_en_s) begin
                rd_addr_r   <= rd_addr_r + 6'd1;
                rd_issued_r <= (rd_addr_r == ADDR_LAST);
            end
            if (last_xfer_s) begin
                rbank_r     <= ~rbank_r;
                rd_issued_r <= 1'b0;
            end
            if (adv_s) begin
                q_vld_r     <= rd_en_s;
                q_last_r    <= rd_en_s & (rd_addr_r == ADDR_LAST);
                out_valid_r <= q_vld_r;
                out_last_r  <= q_vld_r & q_last_r;
                if (q_vld_r) begin
                    out_re_r <= q_data_r[2*DWIDTH-1:DWIDTH];
                    out_im_r <= q_data_r[DWIDTH-1:0];
                end
            end
        end
    end

    assign bus.out_re    = out_re_r;
    assign bus.out_im    = out_im_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;

`ifdef CPREM_OVF_STATUS_EN
    logic ovf_r;

    // Sticky drop indicator, set when a body starts against a still-full bank
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | (enter_body_s & full_r[wbank_r]);
        end
    end

    assign overflow = ovf_r;
`else
    assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_ofdm_cp_remove.sv
// Directed bench for ofdm_cp_remove: sample value n is driven as re=n, im=-n, so every
// expected output is derived from its position in the input stream.
module tb_ofdm_cp_remove;
    localparam int DW  = 16;
    localparam int CPL = 16;

`ifdef CPREM_OVF_STATUS_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic overflow;

    ofdm_cp_remove_if #(.DWIDTH(DW)) bus ();

    ofdm_cp_remove #(.DWIDTH(DW), .CPLEN(CPL)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp     = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int hold_viol = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_re, prev_im;
    logic          prev_last;
    logic [DW-1:0] cap_re[$];
    logic [DW-1:0] cap_im[$];
    logic          cap_last[$];
    int            cap_cyc[$];

    function automatic logic pick_rdy(input int mode);
        if (mode == 2) return ($urandom_range(99, 0) < 30);
        else return (mode == 1);
    endfunction

    // One clock: at the negedge, record the handshake that the next posedge will perform,
    // track output stability during stalls, then drive the new inputs.
    task automatic step(input logic v, input logic s, input int n, input logic r);
        @(negedge clk);
        cyc++;
        if (prev_stall && ((bus.out_valid !== 1'b1) || (bus.out_re !== prev_re) ||
                           (bus.out_im !== prev_im) || (bus.out_last !== prev_last)))
            hold_viol++;
        prev_stall = (bus.out_valid === 1'b1) && !r;
        prev_re    = bus.out_re;
        prev_im    = bus.out_im;
        prev_last  = bus.out_last;
        if ((bus.out_valid === 1'b1) && r) begin
            cap_re.push_back(bus.out_re);
            cap_im.push_back(bus.out_im);
            cap_last.push_back(bus.out_last);
            cap_cyc.push_back(cyc);
        end
        bus.out_ready = r;
        bus.in_valid  = v;
        bus.in_sof    = s;
        bus.in_re     = v ? DW'(n) : '0;
        bus.in_im     = v ? DW'(-n) : '0;
    endtask

    task automatic clear_caps();
        cap_re.delete();
        cap_im.delete();
        cap_last.delete();
        cap_cyc.delete();
        hold_viol  = 0;
        prev_stall = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        rst = 1'b0;
        clear_caps();
    endtask

    task automatic feed(input int start, input int count, input logic sof_first, input int mode);
        for (int i = 0; i < count; i++)
            step(1'b1, sof_first && (i == 0), start + i, pick_rdy(mode));
    endtask

    // Idle input until target outputs have been seen (or the budget runs out), plus a tail
    // so that any surplus output would also be captured.
    task automatic drain(input int target, input int budget, input int mode);
        int k;
        k = 0;
        while ((cap_re.size() < target) && (k < budget)) begin
            step(1'b0, 1'b0, 0, pick_rdy(mode));
            k++;
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 0, pick_rdy(mode));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        rst = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        n_cmp++; if (bus.out_re !== 16'h0000) begin n_fail++; $display("FAIL reset_out_re: got %h want 0000", bus.out_re); end
        n_cmp++; if (bus.out_im !== 16'h0000) begin n_fail++; $display("FAIL reset_out_im: got %h want 0000", bus.out_im); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        clear_caps();
    endtask

    task automatic test_single_symbol();
        int last_in;
        apply_reset();
        feed(0, 80, 1'b1, 1);
        last_in = cyc;
        drain(64, 200, 1);
        n_cmp++; if (cap_re.size() != 64) begin n_fail++; $display("FAIL single_count: got %0d want 64", cap_re.size()); end
        n_cmp++;
        if ((cap_cyc.size() == 0) || (cap_cyc[0] != last_in + 4)) begin
            n_fail++;
            $display("FAIL single_latency: got %0d want 4 cycles", (cap_cyc.size() == 0) ? -1 : cap_cyc[0] - last_in);
        end
        for (int i = 0; i < cap_re.size() && i < 64; i++) begin
            n_cmp++;
            if ((cap_re[i] !== DW'(16 + i)) || (cap_im[i] !== DW'(-(16 + i))) || (cap_last[i] !== (i == 63))) begin
                n_fail++;
                $display("FAIL single_data[%0d]: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                         i, $signed(cap_re[i]), $signed(cap_im[i]), cap_last[i], 16 + i, -(16 + i), (i == 63));
            end
        end
    endtask

    task automatic test_back_to_back();
        int first;
        int exp_v;
        apply_reset();
        first = cyc + 1;
        feed(0, 240, 1'b1, 1);
        drain(192, 400, 1);
        n_cmp++; if (cap_re.size() != 192) begin n_fail++; $display("FAIL b2b_count: got %0d want 192", cap_re.size()); end
        for (int i = 0; i < cap_re.size() && i < 192; i++) begin
            exp_v = (i / 64) * 80 + 16 + (i % 64);
            n_cmp++;
            if ((cap_re[i] !== DW'(exp_v)) || (cap_im[i] !== DW'(-exp_v)) || (cap_last[i] !== ((i % 64) == 63))) begin
                n_fail++;
                $display("FAIL b2b_data[%0d]: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                         i, $signed(cap_re[i]), $signed(cap_im[i]), cap_last[i], exp_v, -exp_v, ((i % 64) == 63));
            end
        end
        for (int s = 0; s < 3; s++) begin
            n_cmp++;
            if ((cap_cyc.size() <= 64 * s) || (cap_cyc[64 * s] != first + 80 * s + 79 + 4)) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: got cycle %0d want %0d", s,
                         (cap_cyc.size() <= 64 * s) ? -1 : cap_cyc[64 * s], first + 80 * s + 83);
            end
        end
    endtask

    task automatic test_random_ready();
        apply_reset();
        feed(0, 80, 1'b1, 2);
        drain(64, 1500, 2);
        n_cmp++; if (cap_re.size() != 64) begin n_fail++; $display("FAIL rand_count: got %0d want 64", cap_re.size()); end
        n_cmp++; if (hold_viol != 0) begin n_fail++; $display("FAIL rand_hold: got %0d unstable stall cycles want 0", hold_viol); end
        for (int i = 0; i < cap_re.size() && i < 64; i++) begin
            n_cmp++;
            if ((cap_re[i] !== DW'(16 + i)) || (cap_im[i] !== DW'(-(16 + i))) || (cap_last[i] !== (i == 63))) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                         i, $signed(cap_re[i]), $signed(cap_im[i]), cap_last[i], 16 + i, -(16 + i), (i == 63));
            end
        end
    endtask

    task automatic test_overflow();
        int exp_v;
        apply_reset();
        feed(0, 320, 1'b1, 0);
        step(1'b0, 1'b0, 0, 1'b0);
        n_cmp++; if (overflow !== OVF_EXP) begin n_fail++; $display("FAIL ovf_flag: got %b want %b", overflow, OVF_EXP); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_waiting_valid: got %b want 1", bus.out_valid); end
        drain(128, 600, 1);
        n_cmp++; if (cap_re.size() != 128) begin n_fail++; $display("FAIL ovf_count: got %0d want 128", cap_re.size()); end
        n_cmp++; if (hold_viol != 0) begin n_fail++; $display("FAIL ovf_hold: got %0d unstable stall cycles want 0", hold_viol); end
        for (int i = 0; i < cap_re.size() && i < 128; i++) begin
            exp_v = (i / 64) * 80 + 16 + (i % 64);
            n_cmp++;
            if ((cap_re[i] !== DW'(exp_v)) || (cap_im[i] !== DW'(-exp_v)) || (cap_last[i] !== ((i % 64) == 63))) begin
                n_fail++;
                $display("FAIL ovf_data[%0d]: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                         i, $signed(cap_re[i]), $signed(cap_im[i]), cap_last[i], exp_v, -exp_v, ((i % 64) == 63));
            end
        end
        n_cmp++;
        if ((cap_cyc.size() < 65) || (cap_cyc[64] - cap_cyc[63] > 3)) begin
            n_fail++;
            $display("FAIL ovf_bank_switch: got gap %0d want <= 3", (cap_cyc.size() < 65) ? -1 : cap_cyc[64] - cap_cyc[63]);
        end
        n_cmp++; if (overflow !== OVF_EXP) begin n_fail++; $display("FAIL ovf_sticky: got %b want %b", overflow, OVF_EXP); end
    endtask

    task automatic test_sof_restart();
        apply_reset();
        feed(0, 46, 1'b1, 1);
        feed(100, 80, 1'b1, 1);
        drain(64, 200, 1);
        n_cmp++; if (cap_re.size() != 64) begin n_fail++; $display("FAIL restart_count: got %0d want 64", cap_re.size()); end
        for (int i = 0; i < cap_re.size() && i < 64; i++) begin
            n_cmp++;
            if ((cap_re[i] !== DW'(116 + i)) || (cap_im[i] !== DW'(-(116 + i))) || (cap_last[i] !== (i == 63))) begin
                n_fail++;
                $display("FAIL restart_data[%0d]: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                         i, $signed(cap_re[i]), $signed(cap_im[i]), cap_last[i], 116 + i, -(116 + i), (i == 63));
            end
        end
    endtask

    task automatic test_reset_midread();
        apply_reset();
        feed(0, 240, 1'b1, 0);
        step(1'b0, 1'b0, 0, 1'b0);
        n_cmp++; if (overflow !== OVF_EXP) begin n_fail++; $display("FAIL midrst_pre_ovf: got %b want %b", overflow, OVF_EXP); end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, 1'b1);
        rst = 1'b1;
        step(1'b0, 1'b0, 0, 1'b1);
        rst = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
        clear_caps();
        feed(200, 80, 1'b1, 1);
        drain(64, 200, 1);
        n_cmp++; if (cap_re.size() != 64) begin n_fail++; $display("FAIL midrst_count: got %0d want 64", cap_re.size()); end
        for (int i = 0; i < cap_re.size() && i < 64; i++) begin
            n_cmp++;
            if ((cap_re[i] !== DW'(216 + i)) || (cap_im[i] !== DW'(-(216 + i))) || (cap_last[i] !== (i == 63))) begin
                n_fail++;
                $display("FAIL midrst_data[%0d]: got re=%0d im=%0d last=%b want re=%0d im=%0d last=%b",
                         i, $signed(cap_re[i]), $signed(cap_im[i]), cap_last[i], 216 + i, -(216 + i), (i == 63));
            end
        end
    endtask

    initial begin
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_symbol();
        test_back_to_back();
        test_random_ready();
        test_overflow();
        test_sof_restart();
        test_reset_midread();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
